// File: rtl/nibble_word_packer.sv
`default_nettype none
// nibble_word_packer: packs IN_W-bit beats into one OUT_W-bit word; in_last flushes a zero-filled partial word.
// Revision: 1.0
module nibble_word_packer #(
   parameter int IN_W      = 4,
   parameter int OUT_W     = 32,
   parameter bit MSB_FIRST = 1'b0,
   parameter int CNT_W     = $clog2(OUT_W / IN_W) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count
);

   localparam int               RATIO    = OUT_W / IN_W;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

   logic [OUT_W-1:0] acc;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] slot;
   logic [OUT_W-1:0] merged;
   logic             in_fire;
   logic             out_fire;
   logic             complete;

   assign in_ready = !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign complete = (idx == LAST_IDX) || in_last;
   assign slot     = MSB_FIRST ? (LAST_IDX - idx) : idx;

   // Unwritten slots stay zero because the accumulator is cleared whenever a word leaves it.
   generate
      for (genvar k = 0; k < RATIO; k++) begin : g_slot
         assign merged[k*IN_W +: IN_W] = (slot == CNT_W'(k)) ? in_data : acc[k*IN_W +: IN_W];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else begin
         if (out_fire) begin
            out_valid <= 1'b0;
         end
         // A completing beat on the same edge as an output accept reloads the register and keeps out_valid high.
         if (in_fire) begin
            if (complete) begin
               out_data  <= merged;
               out_count <= idx + CNT_W'(1);
               out_valid <= 1'b1;
               acc       <= '0;
               idx       <= '0;
            end else begin
               acc <= merged;
               idx <= idx + CNT_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire
